// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file UART dump.
// Optional checksum byte: define REGDUMP_CHECKSUM_EN.
package regdump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    FINISH
  } state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   BYTES_PER_REG  = 4;

  // Wide enough to also index the trailing checksum byte.
  function automatic int idx_width(int num_regs);
    return $clog2(num_regs * BYTES_PER_REG + 1);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; accepts the next byte in the last
// cycle of the stop bit so back-to-back bytes have no gap.
import regdump_pkg::*;

module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic          bit_end;

  assign bit_end  = (cnt == '0);
  assign in_ready = (st == IDLE) ||
                    ((st == STOP) && bit_end);

  // Bit sequencing; tx is registered with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      tx      <= UART_STOP_BIT;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            st  <= START;
            tx  <= UART_START_BIT;
            cnt <= RELOAD;
            sh  <= in_data;
          end
        end
        START: begin
          if (bit_end) begin
            st      <= DATA;
            tx      <= sh[0];
            sh      <= sh >> 1;
            bit_idx <= '0;
            cnt     <= RELOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= RELOAD;
            if (bit_idx == 3'd7) begin
              st <= STOP;
              tx <= UART_STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= sh[0];
              sh      <= sh >> 1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            if (in_valid) begin
              st  <= START;
              tx  <= UART_START_BIT;
              cnt <= RELOAD;
              sh  <= in_data;
            end else begin
              st <= IDLE;
              tx <= UART_STOP_BIT;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          st <= IDLE;
          tx <= UART_STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_uart_tx.sv
// Snapshots the register file on start and streams it as UART bytes.
// Optional checksum byte: define REGDUMP_CHECKSUM_EN.
import regdump_pkg::*;

module regfile_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int NUM_REGS     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_REGS*32-1:0] regfile,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int NUM_BYTES = NUM_REGS * BYTES_PER_REG;
  localparam int IW        = idx_width(NUM_REGS);
  localparam logic [IW-1:0] LAST_DATA = IW'(NUM_BYTES - 1);
`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES);
`else
  localparam logic [IW-1:0] LAST_IDX = LAST_DATA;
`endif

  state_t                 state;
  logic [IW-1:0]          byte_idx;
  logic [NUM_REGS*32-1:0] snap;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  // Byte 0 comes straight from regfile so tx falls on the accept edge;
  // later bytes come from the bottom of the shifting snapshot.
  always_comb begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    case (state)
      IDLE: begin
        in_valid = start;
        in_data  = regfile[7:0];
      end
      START: begin
        in_valid = (byte_idx != LAST_IDX);
`ifdef REGDUMP_CHECKSUM_EN
        in_data  = (byte_idx == LAST_DATA) ? csum : snap[7:0];
`else
        in_data  = snap[7:0];
`endif
      end
      default: begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
    endcase
  end

  // Frame sequencing: accept, hand off bytes, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      snap     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= START;
            busy     <= 1'b1;
            byte_idx <= '0;
            snap     <= regfile >> 8;
`ifdef REGDUMP_CHECKSUM_EN
            csum     <= regfile[7:0];
`endif
          end
        end
        START: begin
          if (in_ready) begin
            if (in_valid) begin
              byte_idx <= byte_idx + IW'(1);
              snap     <= snap >> 8;
`ifdef REGDUMP_CHECKSUM_EN
              csum     <= csum ^ snap[7:0];
`endif
            end else begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .tx      (tx)
  );

endmodule

// File: tb/tb_regfile_uart_tx.sv
// Self-checking bench for regfile_uart_tx (CLKS_PER_BIT=4, NUM_REGS=2).
// Build with REGDUMP_CHECKSUM_EN to expect the trailing checksum byte.
module tb_regfile_uart_tx;

  localparam int CPB = 4;
  localparam int NR  = 2;
  localparam int NB  = NR * 4;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int LAT = (NB + 1) * 10 * CPB + 1;
`else
  localparam int LAT = NB * 10 * CPB + 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NR*32-1:0] regfile = '0;
  logic          tx;
  logic          busy;
  logic          done;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [63:0] rf;
    bit          corrupt;
    bit          restart;
    int          exp_lat;
  } vec_t;

  vec_t tbl[4];

  regfile_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_REGS    (NR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .regfile(regfile),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // UART monitor: every bit must hold for CPB samples.
  always begin : mon
    logic [9:0] bits;
    logic       v;
    bit         abort;
    bit         bad;
    logic [7:0] e;
    @(negedge clk);
    if (!reset && tx == 1'b0) begin
      abort = 0;
      bad   = 0;
      bits  = '0;
      for (int b = 0; b < 10; b++) begin
        for (int s = 0; s < CPB; s++) begin
          if (b != 0 || s != 0) @(negedge clk);
          if (reset) abort = 1;
          if (abort) break;
          if (s == 0) begin
            v = tx;
            bits[b] = v;
          end else if (tx !== v) begin
            bad = 1;
          end
        end
        if (abort) break;
      end
      if (!abort) begin
        chk("bit_timing", {63'd0, bad}, 64'd0);
        chk("frame_bits", {62'd0, bits[9], bits[0]}, 64'd2);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {56'd0, bits[8:1]}, 64'hfff);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {56'd0, bits[8:1]}, {56'd0, e});
        end
      end
    end
  end

  task automatic push_frame(input logic [63:0] rf);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(rf[8*k +: 8]);
      x ^= rf[8*k +: 8];
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic run_frame(input vec_t v);
    int  acc;
    int  d0;
    bit  seen;
    d0 = done_cnt;
    @(posedge clk); #1;
    regfile = v.rf;
    start = 1'b1;
    push_frame(v.rf);
    acc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.corrupt) regfile = '1;
    @(negedge clk);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("tx_start_latency", {63'd0, tx}, 64'd0);
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = (v.restart && cyc == acc + 140);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
    chk("done_latency", 64'(cyc - acc), 64'(v.exp_lat));
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    repeat (30) @(negedge clk);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("all_bytes", 64'(exp_q.size()), 64'd0);
    chk("tx_idle", {63'd0, tx}, 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int bad;
    int d0;
    int acc;
    tbl[0] = '{64'hDEADBEEF_12345678, 1'b0, 1'b0, LAT};
    tbl[1] = '{64'hDEADBEEF_12345678, 1'b1, 1'b0, LAT};
    tbl[2] = '{64'h0F1E2D3C_4B5A6978, 1'b0, 1'b1, LAT};
    tbl[3] = '{64'h00FF8001_A55A0000, 1'b0, 1'b0, LAT};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_tx", {63'd0, tx}, 64'd1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_100", 64'(bad), 64'd0);

    for (int i = 0; i < 4; i++) run_frame(tbl[i]);

    // Reset during the data bits of byte 5.
    d0 = done_cnt;
    @(posedge clk); #1;
    regfile = 64'hCAFEF00D_01234567;
    start = 1'b1;
    push_frame(regfile);
    acc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < acc + 210) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("abort_tx", {63'd0, tx}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_tx_idle", {63'd0, tx}, 64'd1);

    run_frame(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
